// File: rtl/queue_pop_ctrl.sv
// queue_pop_ctrl
// Read-side controller for the shift-register feature queue between conv/pool
// stages. It mirrors the queue occupancy from the producer's push strobe, issues
// single-cycle pops, and presents each popped entry on a registered valid/ready
// output stage. A flush request drains and discards everything queued.
module queue_pop_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             push,
    input  logic             flush,
    input  logic [WIDTH-1:0] q_dout,
    output logic             read_flag,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    state_t           state_q,    state_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_vld_q,  out_vld_d;
    logic             ovf_err_q,  ovf_err_d;

    logic slot_free_s;
    logic at_empty_s;
    logic at_full_s;
    logic pop_s;
    logic flush_start_s;

    // The output register can take a new entry when it is empty or being drained.
    assign slot_free_s   = ~out_vld_q | out_rdy;
    assign at_empty_s    = (count_q == CNT_ZERO);
    assign at_full_s     = (count_q == CNT_FULL);
    // A flush that arrives while already flushing is ignored.
    assign flush_start_s = ce & flush & (state_q != ST_FLUSH);

    // Pop decision: normal pops wait for a free output slot, discard pops do not.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            ST_RUN:   pop_s = ce & ~at_empty_s & slot_free_s;
            ST_FLUSH: pop_s = ce & ~at_empty_s;
            default:  pop_s = 1'b0;
        endcase
    end

    // Occupancy tracking; a push into a full queue without a pop saturates and flags overflow.
    always_comb begin
        count_d   = count_q;
        ovf_err_d = ovf_err_q;
        if (ce) begin
            if (push & ~pop_s) begin
                if (at_full_s) begin
                    ovf_err_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else if (pop_s & ~push) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d   = count_q;
            ovf_err_d = ovf_err_q;
        end
    end

    // Next-state logic: flush entry wins, otherwise follow the post-update occupancy.
    always_comb begin
        state_d = state_q;
        if (!ce) begin
            state_d = state_q;
        end else if (flush_start_s) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = (count_d != CNT_ZERO) ? ST_RUN : ST_IDLE;
                ST_RUN:   state_d = (count_d == CNT_ZERO) ? ST_IDLE : ST_RUN;
                ST_FLUSH: state_d = (count_d == CNT_ZERO) ? ST_IDLE : ST_FLUSH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output stage: capture on a normal pop, drop on accept, never present discarded data.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        if (!ce) begin
            out_vld_d = out_vld_q;
        end else if (flush_start_s) begin
            out_vld_d = 1'b0;
        end else if (state_q == ST_FLUSH) begin
            out_vld_d = 1'b0;
        end else if (pop_s) begin
            out_data_d = q_dout;
            out_vld_d  = 1'b1;
        end else if (out_vld_q & out_rdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= CNT_ZERO;
            out_data_q <= {WIDTH{1'b0}};
            out_vld_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign read_flag = pop_s;
    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign count     = count_q;
    assign empty     = at_empty_s;
    assign full      = at_full_s;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_queue_pop_ctrl.sv
// Bench for queue_pop_ctrl: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (occupancy number, a FIFO standing
// in for the paired queue, and the presented output entry).
module tb_queue_pop_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             push;
    logic             flush;
    logic [WIDTH-1:0] q_dout;
    logic             read_flag;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             out_rdy;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf_err;

    logic [WIDTH-1:0] push_data;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int               m_cnt;
    bit               m_vld;
    bit               m_ovf;
    bit               m_flushing;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] env_q[$];      // contents of the paired queue
    logic [WIDTH-1:0] accepted[$];   // entries taken downstream
    int               rf_pulses;

    queue_pop_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .push      (push),
        .flush     (flush),
        .q_dout    (q_dout),
        .read_flag (read_flag),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt      = 0;
        m_vld      = 1'b0;
        m_ovf      = 1'b0;
        m_flushing = 1'b0;
        m_data     = '0;
        env_q.delete();
    endtask

    // Assert reset asynchronously, check outputs clear at once, release after the next edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_out_vld",   out_vld,   32'd0);
        check("rst_out_data",  out_data,  32'd0);
        check("rst_count",     count,     32'd0);
        check("rst_ovf_err",   ovf_err,   32'd0);
        check("rst_read_flag", read_flag, 32'd0);
        check("rst_empty",     empty,     32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic step();
        bit               exp_rf;
        int               n_cnt;
        bit               n_vld;
        bit               n_ovf;
        bit               n_fl;
        logic [WIDTH-1:0] n_data;
        q_dout = (env_q.size() > 0) ? env_q[0] : WIDTH'($urandom);
        @(negedge clk);
        exp_rf = ce && (m_cnt > 0) && (m_flushing || !m_vld || out_rdy);
        check("read_flag", read_flag, exp_rf);
        check("out_vld",   out_vld,   m_vld);
        check("out_data",  out_data,  m_data);
        check("count",     count,     m_cnt);
        check("empty",     empty,     (m_cnt == 0));
        check("full",      full,      (m_cnt == DEPTH));
        check("ovf_err",   ovf_err,   m_ovf);
        if (read_flag) rf_pulses++;
        if (ce && out_vld && out_rdy) accepted.push_back(out_data);
        n_cnt = m_cnt; n_vld = m_vld; n_ovf = m_ovf; n_fl = m_flushing; n_data = m_data;
        if (ce) begin
            if (push && !exp_rf) begin
                if (m_cnt == DEPTH) n_ovf = 1'b1;
                else n_cnt++;
            end else if (exp_rf && !push) begin
                n_cnt--;
            end
            if (exp_rf) void'(env_q.pop_front());
            if (push && env_q.size() < DEPTH) env_q.push_back(push_data);
            if (flush && !m_flushing) begin
                n_fl  = 1'b1;
                n_vld = 1'b0;
            end else if (m_flushing) begin
                n_vld = 1'b0;
                if (n_cnt == 0) n_fl = 1'b0;
            end else if (exp_rf) begin
                n_data = q_dout;
                n_vld  = 1'b1;
            end else if (m_vld && out_rdy) begin
                n_vld = 1'b0;
            end
        end
        m_cnt = n_cnt; m_vld = n_vld; m_ovf = n_ovf; m_flushing = n_fl; m_data = n_data;
        @(posedge clk);
        #1;
    endtask

    // Push 0x11, 0x22, 0x33 on consecutive cycles.
    task automatic push_three();
        logic [WIDTH-1:0] vals[3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_data = vals[i];
            step();
        end
        push = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; push = 1'b0; flush = 1'b0; out_rdy = 1'b0;
        push_data = '0; q_dout = '0; rf_pulses = 0;
        model_reset();
        #2;
        do_reset();

        // 1) stream three entries with downstream always ready
        ce = 1'b1; out_rdy = 1'b1;
        accepted.delete();
        push_three();
        repeat (6) step();
        check("t1_n_accepted", accepted.size(), 32'd3);
        if (accepted.size() == 3) begin
            check("t1_data0", accepted[0], 32'h11);
            check("t1_data1", accepted[1], 32'h22);
            check("t1_data2", accepted[2], 32'h33);
        end
        check("t1_count", count, 32'd0);

        // 2) fill with downstream stalled, then drain back-to-back
        do_reset();
        ce = 1'b1; out_rdy = 1'b0;
        push_three();
        repeat (2) step();
        check("t2_count",    count,    32'd2);
        check("t2_out_vld",  out_vld,  32'd1);
        check("t2_out_data", out_data, 32'h11);
        out_rdy = 1'b1;
        accepted.delete();
        repeat (3) step();
        check("t2_n_accepted", accepted.size(), 32'd3);
        if (accepted.size() == 3) begin
            check("t2_data1", accepted[1], 32'h22);
            check("t2_data2", accepted[2], 32'h33);
        end

        // 3) full queue with push+pop each cycle, then overflow
        do_reset();
        ce = 1'b1; out_rdy = 1'b0; push = 1'b1;
        for (int i = 0; i < 10 && m_cnt < DEPTH; i++) begin
            push_data = WIDTH'($urandom);
            step();
        end
        check("t3_filled", count, 32'd3);
        out_rdy = 1'b1;
        repeat (5) begin
            push_data = WIDTH'($urandom);
            step();
        end
        check("t3_count_hold", count,   32'd3);
        check("t3_no_ovf",     ovf_err, 32'd0);
        out_rdy = 1'b0;
        step();
        push = 1'b0;
        step();
        check("t3_ovf",       ovf_err, 32'd1);
        check("t3_count_ovf", count,   32'd3);

        // 4) flush with two queued entries and a presented entry
        do_reset();
        ce = 1'b1; out_rdy = 1'b0;
        push_three();
        step();
        rf_pulses = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_vld_cleared", out_vld, 32'd0);
        repeat (5) step();
        check("t4_rf_pulses", rf_pulses, 32'd2);
        check("t4_count",     count,     32'd0);
        check("t4_out_vld",   out_vld,   32'd0);

        // 5) reset in the middle of traffic
        do_reset();
        ce = 1'b1; out_rdy = 1'b0;
        push_three();
        step();
        out_rdy = 1'b1;
        do_reset();

        // 6) clock enable low holds everything
        ce = 1'b1; out_rdy = 1'b0;
        push_three();
        step();
        ce = 1'b0; out_rdy = 1'b1;
        rf_pulses = 0;
        repeat (4) step();
        check("t6_rf_pulses", rf_pulses, 32'd0);
        check("t6_count",     count,     32'd2);
        check("t6_out_vld",   out_vld,   32'd1);
        check("t6_out_data",  out_data,  32'h11);
        ce = 1'b1;
        repeat (4) step();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ce        = ($urandom_range(0, 9) != 0);
            push      = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 39) == 0);
            out_rdy   = ($urandom_range(0, 9) < 6);
            push_data = WIDTH'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
